// File: rtl/bus_serializer.sv
// bus_serializer: parallel word to UART-style serial frame (start, LSB-first data, optional parity, stop)
// Ports: clk, rst_n (async active-low), in_data/in_valid/in_ready (word handshake),
//        ser_out (registered serial line, idle 1), busy (frame in progress), done (last frame cycle).
// Define BUS_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module bus_serializer #(
  parameter int BUS_WIDTH = 32,
  parameter int DIV       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ser_out,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_next;
  logic [7:0]           r_div;
  logic [BW-1:0]        r_bit;
  logic [BUS_WIDTH-1:0] r_shift, w_shift_next;
  logic                 r_ser, r_ready, w_tick, w_accept, w_last_bit, w_ser_next;
`ifdef BUS_SERIALIZER_PARITY_EN
  logic                 r_par;
`endif
  assign w_tick       = r_div == 8'd0;
  assign w_accept     = in_valid && r_ready;
  assign w_last_bit   = r_bit == BW'(BUS_WIDTH - 1);
  assign w_shift_next = w_accept ? in_data : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
  assign in_ready     = r_ready;
  assign ser_out      = r_ser;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? START : IDLE;
      START:   w_next = w_tick ? DATA : START;
`ifdef BUS_SERIALIZER_PARITY_EN
      DATA:    w_next = (w_tick && w_last_bit) ? PARITY : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
`else
      DATA:    w_next = (w_tick && w_last_bit) ? STOP : DATA;
`endif
      STOP:    w_next = w_tick ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // ser_out is registered, so its next value is derived from the state and shift contents about to be entered
  always_comb begin
    busy       = r_state != IDLE;
    done       = r_state == STOP && w_tick;
    w_ser_next = 1'b1;
`ifdef BUS_SERIALIZER_PARITY_EN
    w_ser_next = (w_next == PARITY) ? r_par : w_ser_next;
`endif
    w_ser_next = (w_next == START) ? 1'b0 : (w_next == DATA) ? w_shift_next[0] : w_ser_next;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ser   <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_div   <= (r_state == IDLE || w_tick) ? 8'(DIV - 1) : r_div - 8'd1;
      r_bit   <= (r_state != DATA) ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
      r_shift <= w_shift_next;
      r_ser   <= w_ser_next;
      r_ready <= w_next == IDLE;
    end
`ifdef BUS_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        r_par <= 1'b0;
    else if (w_accept) r_par <= ^in_data;
`endif
endmodule

// File: tb/tb_bus_serializer.sv
// tb_bus_serializer: random and directed checks of bus_serializer against a frame-list model
module tb_bus_serializer;
`ifdef BUS_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v[2];
  logic [63:0] d[2];
  logic        so[2], bz[2], dn[2], rd[2];
  int          checks = 0, failures = 0;
  int          wid[2] = '{8, 32};
  int          dv[2] = '{1, 4};
  logic [3:0]  cur[2] = '{4'b1000, 4'b1000};
  logic [3:0]  q[2][$];
  always #5 clk = ~clk;
  bus_serializer #(.BUS_WIDTH(8), .DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(d[0][7:0]), .in_valid(v[0]),
    .in_ready(rd[0]), .ser_out(so[0]), .busy(bz[0]), .done(dn[0]));
  bus_serializer #(.BUS_WIDTH(32), .DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(d[1][31:0]), .in_valid(v[1]),
    .in_ready(rd[1]), .ser_out(so[1]), .busy(bz[1]), .done(dn[1]));
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction
  // expected per-cycle {ser_out, busy, done, in_ready} for a whole frame
  task automatic build(input int i);
    int          n = wid[i] + 2 + P;
    logic [63:0] m = (64'd1 << wid[i]) - 64'd1;
    logic        b;
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? 1'b0 : (k <= wid[i]) ? d[i][k-1] : (P == 1 && k == wid[i] + 1) ? ^(d[i] & m) : 1'b1;
      for (int c = 0; c < dv[i]; c++) q[i].push_back({b, 1'b1, (k == n - 1 && c == dv[i] - 1), 1'b0});
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q[i].delete();
        cur[i] = 4'b1000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (q[i].size() != 0) cur[i] = q[i].pop_front();
        else if (cur[i][0] && v[i]) begin
          build(i);
          cur[i] = q[i].pop_front();
        end else cur[i] = 4'b1001;
      end
    end
  end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) chk($sformatf("cycle_u%0d", i), {60'd0, so[i], bz[i], dn[i], rd[i]}, {60'd0, cur[i]});
  task automatic send(input int i, input logic [63:0] x, input bit hold);
    int t = 0;
    while (rd[i] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(t < 200), 64'd1);
    v[i] = 1'b1;
    d[i] = x;
    @(negedge clk);
    if (!hold) v[i] = 1'b0;
  endtask
  task automatic capture(input int i, input int n, output logic [63:0] s, output logic [63:0] dd);
    s  = '0;
    dd = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      s  = {s[62:0], so[i]};
      dd = {dd[62:0], dn[i]};
    end
  endtask
  initial begin
    logic [63:0] s, dd;
    int          busy_n, zeros, rdbad, t;
    v[0] = 1'b0; v[1] = 1'b0; d[0] = '0; d[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_a", {60'd0, so[0], bz[0], dn[0], rd[0]}, 64'b1000);
    chk("reset_b", {60'd0, so[1], bz[1], dn[1], rd[1]}, 64'b1000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {62'd0, rd[0], rd[1]}, 64'b11);
    send(0, 64'hA5, 1'b0);
    capture(0, 10 + P, s, dd);
    chk("a5_ser", s, P ? 64'b01010010101 : 64'b0101001011);
    chk("a5_done", dd, 64'd1);
    send(0, 64'h01, 1'b0);
    capture(0, 10 + P, s, dd);
    chk("x01_ser", s, P ? 64'b01000000011 : 64'b0100000001);
    send(0, 64'h11, 1'b1);
    d[0] = 64'h22;
    capture(0, 21 + 2 * P, s, dd);
    v[0] = 1'b0;
    chk("b2b_ser", s, P ? 64'b01000100001100100010001 : 64'b010001000110010001001);
    chk("b2b_done", 64'($countones(dd)), 64'd2);
    send(1, 64'hFFFF0000, 1'b0);
    busy_n = 0; zeros = 0; rdbad = 0; t = 0;
    while (bz[1] === 1'b1 && t < 400) begin
      busy_n++;
      if (so[1] === 1'b0) zeros++;
      if (rd[1] !== 1'b0) rdbad++;
      @(negedge clk);
      t++;
    end
    chk("w32_busy_len", 64'(busy_n), 64'(136 + 4 * P));
    chk("w32_zero_cycles", 64'(zeros), 64'(68 + 4 * P));
    chk("w32_ready_low", 64'(rdbad), 64'd0);
    send(0, 64'hC3, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {60'd0, so[0], bz[0], dn[0], rd[0]}, 64'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 64'h5A, 1'b0);
    capture(0, 10 + P, s, dd);
    chk("after_rst_ser", s, P ? 64'b00101101001 : 64'b0010110101);
    chk("after_rst_done", dd, 64'd1);
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        v[i] = 1'($urandom_range(0, 1));
        d[i] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (50) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_serializer.md
BUS_SERIALIZER -- requirements
Module: bus_serializer

Interface
REQ-001 Parameter BUS_WIDTH, default 32, parallel word width in bits; legal range 2..64.
REQ-002 Parameter DIV, default 4, clock cycles per serial bit period; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_data  input  BUS_WIDTH  parallel word to transmit.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port ser_out  output  1  serial line; idle level 1.
REQ-009 Port busy  output  1  frame in progress (any state other than IDLE).
REQ-010 Port done  output  1  one-cycle pulse on the last cycle of a frame.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 The block SHALL assert in_ready only in IDLE; a word is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-013 On acceptance, in_data SHALL be captured into an internal shift register, and the state SHALL go to START on the same edge; later changes on in_data have no effect.
REQ-014 ser_out SHALL be registered: 0 for one bit period in START, then BUS_WIDTH data bits LSB first in DATA, then 1 for one bit period in STOP.
REQ-015 Each bit SHALL be held for exactly DIV cycles, timed by a divide counter that reloads at each bit boundary.
REQ-016 A bit counter SHALL count data bits 0..BUS_WIDTH-1; DATA SHALL exit after bit BUS_WIDTH-1 completes, with no off-by-one at either end.
REQ-017 ser_out SHALL fall to 0 on the cycle immediately after the acceptance edge (latency 1 cycle).
REQ-018 Frame length SHALL be (BUS_WIDTH+2+P)*DIV cycles, where P=1 with the parity feature compiled in and 0 otherwise.
REQ-019 done SHALL pulse high for exactly one cycle, on the final cycle of STOP; STOP SHALL then transition to IDLE.
REQ-020 Back-to-back: in_ready SHALL be 1 on the cycle after STOP ends, giving a minimum of one idle (ser_out=1) cycle between frames.
REQ-021 in_valid asserted while busy SHALL be ignored, with no capture and no side effect.
REQ-022 With DIV=1, each state SHALL last exactly one cycle per bit and no cycle SHALL be skipped or duplicated.

Reset
REQ-023 On rst_n=0, the block SHALL asynchronously force state=IDLE, ser_out=1, in_ready=0, busy=0, done=0, and clear both counters and the shift register.
REQ-024 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with no done pulse and no resumption.

Configuration
REQ-026 Macro BUS_SERIALIZER_PARITY_EN, when defined, SHALL enable the PARITY state between DATA and STOP, transmitting for one bit period the even-parity bit (XOR of all captured data bits).
REQ-027 Without BUS_SERIALIZER_PARITY_EN, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesized.

Verification
REQ-028 BUS_WIDTH=8, DIV=1, no parity, send 0xA5 -> ser_out from the cycle after acceptance = 0,1,0,1,0,0,1,0,1,1; done high on the 10th cycle only.
REQ-029 Same as REQ-028 with BUS_SERIALIZER_PARITY_EN and 0xA5 -> 0,1,0,1,0,0,1,0,1,0,1; then send 0x01 -> parity bit 1; frame length 11 cycles.
REQ-030 BUS_WIDTH=32, DIV=4, send 0xFFFF0000 -> each level held 4 cycles; busy high for 136 cycles; in_ready low throughout.
REQ-031 in_valid held high continuously with words 0x11, 0x22 (BUS_WIDTH=8, DIV=1) -> two frames separated by exactly one idle cycle, 0x11 transmitted first; no word dropped or duplicated.
REQ-032 rst_n pulsed low at data bit 3 of a frame -> ser_out=1 and busy=0 asynchronously; no done pulse; the next accepted word is transmitted intact.
